// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC register, 1-cycle-latency imem request port,
// DEPTH-entry instruction queue to decode, internal branch/jump redirect.
module fetch_unit #(
  parameter int unsigned          PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC = '0,
  parameter int unsigned          DEPTH    = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  output logic                        imem_req,
  output logic [PC_WIDTH-1:0]         imem_addr,
  input  logic [31:0]                 imem_rdata,
  input  logic                        redir_valid,
  input  logic                        redir_kind,
  input  logic [PC_WIDTH-1:0]         redir_base,
  input  logic [25:0]                 redir_imm,
  output logic                        dec_valid,
  input  logic                        dec_ready,
  output logic [31:0]                 dec_instr,
  output logic [PC_WIDTH-1:0]         dec_pc,
  output logic [PC_WIDTH-1:0]         dec_pc_plus4,
  output logic [$clog2(DEPTH):0]      q_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] inflight_pc;
  logic                inflight;
  logic [31:0]         q_instr [DEPTH];
  logic [PC_WIDTH-1:0] q_pc    [DEPTH];
  logic [AW-1:0]       rd_ptr;
  logic [AW-1:0]       wr_ptr;
  logic [CW-1:0]       count;

  logic                pop;
  logic                push;
  logic                issue;
  logic                head_valid;
  logic [CW:0]         occ_after;
  logic [PC_WIDTH-1:0] br_off;
  logic [PC_WIDTH-1:0] jmp_target;
  logic [PC_WIDTH-1:0] target;

  // Branch offset: sign-extended word offset, fitted to PC_WIDTH
  if (PC_WIDTH <= 32) begin : g_br_narrow
    logic [31:0] off32;
    assign off32  = {{14{redir_imm[15]}}, redir_imm[15:0], 2'b00};
    assign br_off = off32[PC_WIDTH-1:0];
  end else begin : g_br_wide
    assign br_off = {{(PC_WIDTH-16){redir_imm[15]}}, redir_imm[15:0], 2'b00};
  end

  // Jump target: region bits from the base above bit 27 when they exist
  if (PC_WIDTH > 28) begin : g_jmp_region
    assign jmp_target = {redir_base[PC_WIDTH-1:28], redir_imm, 2'b00};
  end else begin : g_jmp_narrow
    logic [27:0] jmp28;
    assign jmp28      = {redir_imm, 2'b00};
    assign jmp_target = jmp28[PC_WIDTH-1:0];
  end

  // Issue/push/pop decisions and the word-aligned redirect target
  always_comb begin
    head_valid = (count != '0);
    pop        = head_valid && dec_ready && !redir_valid;
    push       = inflight && !redir_valid;
    occ_after  = (CW+1)'(count) + (CW+1)'(inflight) - (CW+1)'(pop);
    issue      = !reset && !redir_valid && (occ_after < (CW+1)'(DEPTH));
    target     = (redir_kind ? jmp_target : (redir_base + br_off)) & ~PC_WIDTH'(3);
  end

  assign imem_req     = issue;
  assign imem_addr    = pc;
  assign dec_valid    = head_valid;
  assign dec_instr    = head_valid ? q_instr[rd_ptr] : 32'd0;
  assign dec_pc       = head_valid ? q_pc[rd_ptr] : '0;
  assign dec_pc_plus4 = head_valid ? (q_pc[rd_ptr] + PC_WIDTH'(4)) : '0;
  assign q_count      = count;

  // PC, in-flight tracking, queue pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else if (redir_valid) begin
      pc       <= target;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (issue) begin
        pc          <= pc + PC_WIDTH'(4);
        inflight_pc <= pc;
      end
      inflight <= issue;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Queue storage, written with the returning instruction and its address
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      q_instr[wr_ptr] <= imem_rdata;
      q_pc[wr_ptr]    <= inflight_pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: main 32-bit instance plus 16- and 8-bit
// instances for truncated jump targets and PC wrap. Scoreboard of expected PCs.
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redir_valid;
  logic        redir_kind;
  logic [31:0] redir_base;
  logic [25:0] redir_imm;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic [31:0] dec_pc_plus4;
  logic [2:0]  q_count;

  logic        req16, dv16, rdy16;
  logic [15:0] addr16, dp16, dpp16;
  logic [31:0] rdata16, di16;
  logic [2:0]  qc16;

  logic        req8, dv8, rdy8, rv8;
  logic [7:0]  addr8, dp8, dpp8;
  logic [31:0] rdata8, di8;
  logic [2:0]  qc8;

  fetch_unit #(.PC_WIDTH(32), .RESET_PC(32'h40), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redir_valid(redir_valid), .redir_kind(redir_kind),
    .redir_base(redir_base), .redir_imm(redir_imm), .dec_valid(dec_valid),
    .dec_ready(dec_ready), .dec_instr(dec_instr), .dec_pc(dec_pc),
    .dec_pc_plus4(dec_pc_plus4), .q_count(q_count)
  );

  fetch_unit #(.PC_WIDTH(16), .RESET_PC(16'h0), .DEPTH(4)) dut16 (
    .clk(clk), .reset(reset), .imem_req(req16), .imem_addr(addr16),
    .imem_rdata(rdata16), .redir_valid(redir_valid), .redir_kind(redir_kind),
    .redir_base(redir_base[15:0]), .redir_imm(redir_imm), .dec_valid(dv16),
    .dec_ready(rdy16), .dec_instr(di16), .dec_pc(dp16),
    .dec_pc_plus4(dpp16), .q_count(qc16)
  );

  fetch_unit #(.PC_WIDTH(8), .RESET_PC(8'hF8), .DEPTH(4)) dut8 (
    .clk(clk), .reset(reset), .imem_req(req8), .imem_addr(addr8),
    .imem_rdata(rdata8), .redir_valid(rv8), .redir_kind(redir_kind),
    .redir_base(redir_base[7:0]), .redir_imm(redir_imm), .dec_valid(dv8),
    .dec_ready(rdy8), .dec_instr(di8), .dec_pc(dp8),
    .dec_pc_plus4(dpp8), .q_count(qc8)
  );

  // Instruction memory models: data = address ^ 0xA5A5, one cycle later
  always @(posedge clk) begin
    imem_rdata <= imem_addr ^ 32'h0000_A5A5;
    rdata16    <= {16'h0, addr16} ^ 32'h0000_A5A5;
    rdata8     <= {24'h0, addr8} ^ 32'h0000_A5A5;
  end

  int n_cmp = 0;
  int n_mis = 0;
  int n_pop = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_load(input logic [31:0] start, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  // One clock: score any accepted head on the falling edge, return at posedge+1
  task automatic tick();
    logic [31:0] e;
    @(negedge clk);
    if (!reset && !redir_valid && dec_valid && dec_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_mis++;
        $error("FAIL sb_underrun: observed pc %h expected none", dec_pc);
      end else begin
        e = exp_q.pop_front();
        chk("dec_pc", dec_pc, e);
        chk("dec_instr", dec_instr, e ^ 32'h0000_A5A5);
        chk("dec_pc_plus4", dec_pc_plus4, e + 32'd4);
        n_pop++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset = 1'b1; redir_valid = 1'b0; redir_kind = 1'b0;
    redir_base = '0; redir_imm = '0; dec_ready = 1'b0;
    rdy16 = 1'b1; rdy8 = 1'b1; rv8 = 1'b0;
    repeat (3) tick();

    // reset state
    chk("rst_req", imem_req, 0);
    chk("rst_valid", dec_valid, 0);
    chk("rst_q_count", q_count, 0);
    chk("rst_dec_pc", dec_pc, 0);
    chk("rst_dec_instr", dec_instr, 0);
    chk("rst_dec_pc_plus4", dec_pc_plus4, 0);

    // first fetch latency and steady streaming
    sb_load(32'h40, 64);
    dec_ready = 1'b1;
    reset = 1'b0;
    #1;
    chk("c0_req", imem_req, 1);
    chk("c0_addr", imem_addr, 32'h40);
    chk("c0_valid", dec_valid, 0);
    chk("w8_c0_addr", addr8, 8'hF8);
    tick();
    chk("c1_valid", dec_valid, 0);
    chk("c1_addr", imem_addr, 32'h44);
    chk("w8_c1_addr", addr8, 8'hFC);
    tick();
    chk("c2_valid", dec_valid, 1);
    chk("c2_pc", dec_pc, 32'h40);
    chk("w8_wrap_addr", addr8, 8'h00);
    chk("w8_wrap_req", req8, 1);
    chk("w8_c2_pc", dp8, 8'hF8);
    tick();
    chk("w8_c3_pc", dp8, 8'hFC);
    chk("w8_c3_plus4", dpp8, 8'h00);
    chk("c3_pc", dec_pc, 32'h44);
    tick();
    chk("w8_c4_pc", dp8, 8'h00);
    chk("c4_pc", dec_pc, 32'h48);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stream_valid", dec_valid, 1);
    end

    // reset mid-stream
    reset = 1'b1;
    exp_q.delete();
    tick();
    chk("mr_valid", dec_valid, 0);
    chk("mr_q_count", q_count, 0);
    chk("mr_req", imem_req, 0);
    chk("mr_dec_pc", dec_pc, 0);

    // fill to DEPTH with decode stalled, then drain
    sb_load(32'h40, 64);
    dec_ready = 1'b0;
    reset = 1'b0;
    #1;
    chk("restart_addr", imem_addr, 32'h40);
    k = 0;
    while (q_count != 3'd4 && k < 12) begin tick(); k++; end
    chk("fill_q_count", q_count, 4);
    chk("full_req", imem_req, 0);
    tick();
    chk("full_hold_q", q_count, 4);
    chk("full_hold_req", imem_req, 0);
    chk("full_head_pc", dec_pc, 32'h40);
    dec_ready = 1'b1;
    #1;
    chk("resume_req", imem_req, 1);
    chk("resume_addr", imem_addr, 32'h50);
    repeat (8) tick();

    // branch redirect
    redir_valid = 1'b1; redir_kind = 1'b0;
    redir_base = 32'h100; redir_imm = 26'h000FFFE;
    sb_load(32'hF8, 64);
    #1;
    chk("br_req_blocked", imem_req, 0);
    tick();
    redir_valid = 1'b0;
    #1;
    chk("br_addr", imem_addr, 32'hF8);
    chk("br_req", imem_req, 1);
    chk("br_q_count", q_count, 0);
    chk("br_valid", dec_valid, 0);
    k = 0;
    while (!dec_valid && k < 6) begin tick(); k++; end
    chk("br_first_valid", dec_valid, 1);
    chk("br_first_pc", dec_pc, 32'hF8);
    repeat (3) tick();

    // queue at 3, back-to-back branch then jump with a pop offered
    dec_ready = 1'b0;
    k = 0;
    while (q_count != 3'd3 && k < 10) begin tick(); k++; end
    chk("q_at_3", q_count, 3);
    dec_ready = 1'b1;
    redir_valid = 1'b1; redir_kind = 1'b0;
    redir_base = 32'h100; redir_imm = 26'h000FFFE;
    sb_load(32'hF8, 64);
    #1;
    chk("b2b_req0", imem_req, 0);
    tick();
    chk("flush_q_count", q_count, 0);
    chk("flush_valid", dec_valid, 0);
    redir_kind = 1'b1;
    redir_base = 32'h1000_0004; redir_imm = 26'h0000040;
    sb_load(32'h1000_0100, 64);
    #1;
    chk("b2b_req1", imem_req, 0);
    tick();
    redir_valid = 1'b0;
    #1;
    chk("jmp_addr", imem_addr, 32'h1000_0100);
    chk("jmp_req", imem_req, 1);
    chk("jmp16_addr", addr16, 16'h0100);
    chk("jmp_q_count", q_count, 0);
    repeat (4) tick();
    chk("jmp_stream_valid", dec_valid, 1);
    chk("jmp16_stream_valid", dv16, 1);
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
